i2s_tx_sched: RTL and testbench

Master-mode controller that sequences the I2S transmitter from the system clock. It generates sclk and lrclk, buffers stereo samples from upstream in a small FIFO behind a valid/ready handshake, and presents one {left,right} pair per frame on left_chan/right_chan. Each pair is held stable for a full frame, so the transmitter's capture on the lrclk rising edge always sees settled data. The block sits between the audio sample source (DSP or synth) and the I2S transmitter.

---
 rtl/i2s_pkg.sv | 27 ++
 rtl/i2s_sample_fifo.sv | 87 ++++++++
 rtl/i2s_tx_sched.sv | 213 +++++++++++++++++++++
 tb/tb_i2s_tx_sched.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S transmit scheduler:
//   - I2S_BITSIZE    : default sample width per channel
//   - ST_IDLE/RUN/STOP: scheduler FSM state encoding
//   - level_width()  : occupancy counter width for a given FIFO depth
//   - I2S_LEVEL_W    : occupancy width for the default FIFO depth
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int unsigned I2S_BITSIZE    = 16;
    localparam int unsigned I2S_FIFO_DEPTH = 4;

    // Plain constants rather than an enum so the encoding stays fixed for
    // older tools and external debug probes.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned I2S_LEVEL_W = $clog2(I2S_FIFO_DEPTH) + 1;

endpackage

// File: rtl/i2s_sample_fifo.sv
// ---------------------------------------------------------------------------
// i2s_sample_fifo
// Synchronous single-clock FIFO holding {left,right} sample pairs.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset (flushes the FIFO)
//   i_push/i_wdata: write request and data (ignored while full)
//   i_pop         : read request (ignored while empty); o_rdata shows head
//   o_full        : registered full flag
//   o_empty       : occupancy is zero
//   o_level       : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_wdata,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [level_width(DEPTH)-1:0] o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = level_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_full;

    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [LVL_W-1:0] w_level_d;

    assign w_empty   = (r_level == '0);
    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_comb begin
        w_level_d = r_level;
        if (w_do_push && !w_do_pop) begin
            w_level_d = r_level + LVL_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_level_d = r_level - LVL_W'(1);
        end
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_d;
            r_full  <= (w_level_d == LVL_W'(DEPTH));
        end
    end

    // Storage needs no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule

// File: rtl/i2s_tx_sched.sv
// ---------------------------------------------------------------------------
// i2s_tx_sched
// Master-mode I2S transmit scheduler. Derives sclk/lrclk from clk, buffers
// stereo pairs from upstream and presents one pair per frame, held for the
// whole frame.
// Ports:
//   clk, rst            : system clock, asynchronous active-low reset
//   enable              : run request (drop -> finish frame, then idle)
//   s_valid/s_ready     : upstream handshake, s_ready = FIFO not full
//   s_left/s_right      : upstream sample pair
//   sclk, lrclk         : registered I2S bit clock and word select
//   left_chan/right_chan: pair presented to the transmitter
//   frame_tick          : one-clk pulse on each frame start
//   underrun            : sticky, set when a frame starts with FIFO empty
//   clr_underrun        : clears underrun (a coincident set wins)
//   level               : FIFO occupancy
// ---------------------------------------------------------------------------
module i2s_tx_sched
    import i2s_pkg::*;
#(
    parameter int unsigned BITSIZE    = I2S_BITSIZE,
    parameter int unsigned SCLK_DIV   = 4,
    parameter int unsigned SLOT       = 32,
    parameter int unsigned FIFO_DEPTH = I2S_FIFO_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [BITSIZE-1:0]                 s_left,
    input  logic [BITSIZE-1:0]                 s_right,
    output logic                               sclk,
    output logic                               lrclk,
    output logic [BITSIZE-1:0]                 left_chan,
    output logic [BITSIZE-1:0]                 right_chan,
    output logic                               frame_tick,
    output logic                               underrun,
    input  logic                               clr_underrun,
    output logic [level_width(FIFO_DEPTH)-1:0] level
);

    localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(2 * SLOT);
    localparam int unsigned LVL_W = level_width(FIFO_DEPTH);

    // State and timing registers
    logic [1:0]         r_state;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic               r_sclk;
    logic               r_lrclk;

    // Presented sample pair and status
    logic [BITSIZE-1:0] r_left;
    logic [BITSIZE-1:0] r_right;
    logic               r_frame_tick;
    logic               r_underrun;

    logic [1:0]         w_state_d;
    logic               w_running;
    logic               w_div_wrap;
    logic               w_sclk_fall;
    logic               w_bit_last;
    logic [BIT_W-1:0]   w_bit_next;
    logic               w_frame_wrap;
    logic               w_frame_start;

    logic               w_fifo_push;
    logic               w_fifo_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [2*BITSIZE-1:0] w_fifo_rdata;
    logic [LVL_W-1:0]   w_fifo_level;

    // ------------------------------------------------------------------
    // Timing decode
    // ------------------------------------------------------------------
    assign w_running    = (r_state != ST_IDLE);
    assign w_div_wrap   = w_running && (r_div_cnt == DIV_W'(SCLK_DIV - 1));
    assign w_sclk_fall  = w_div_wrap && r_sclk;
    assign w_bit_last   = (r_bit_cnt == BIT_W'(2 * SLOT - 1));
    assign w_bit_next   = w_bit_last ? '0 : r_bit_cnt + BIT_W'(1);
    assign w_frame_wrap = w_sclk_fall && w_bit_last;

    // ------------------------------------------------------------------
    // FSM next state and frame-start decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state;
        w_frame_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_d     = ST_RUN;
                    w_frame_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_d = ST_STOP;
                end
                w_frame_start = w_frame_wrap;
            end
            ST_STOP: begin
                // Re-enable resumes seamlessly; a wrap on that same edge is
                // treated as a normal running frame start.
                if (enable) begin
                    w_state_d     = ST_RUN;
                    w_frame_start = w_frame_wrap;
                end else if (w_frame_wrap) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Divider, bit counter, sclk/lrclk
    // ------------------------------------------------------------------
    // A STOP->IDLE wrap naturally lands on sclk=0, lrclk=0, counters=0, so
    // the counting path needs no special case for it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_lrclk   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (r_state == ST_IDLE) begin
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_sclk    <= 1'b0;
                r_lrclk   <= 1'b0;
            end else begin
                r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
                if (w_div_wrap) begin
                    r_sclk <= ~r_sclk;
                end
                if (w_sclk_fall) begin
                    r_bit_cnt <= w_bit_next;
                    r_lrclk   <= (w_bit_next >= BIT_W'(SLOT));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    assign w_fifo_push = s_valid && !w_fifo_full;
    assign w_fifo_pop  = w_frame_start && !w_fifo_empty;

    i2s_sample_fifo #(
        .WIDTH (2 * BITSIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_wdata ({s_left, s_right}),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    // ------------------------------------------------------------------
    // Frame outputs: load the head (or mute) only at frame start, which
    // coincides with lrclk falling, giving half a frame of settling before
    // the transmitter captures on lrclk rising.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_left       <= '0;
            r_right      <= '0;
            r_frame_tick <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_start;
            if (w_frame_start) begin
                if (w_fifo_empty) begin
                    r_left  <= '0;
                    r_right <= '0;
                end else begin
                    r_left  <= w_fifo_rdata[2*BITSIZE-1:BITSIZE];
                    r_right <= w_fifo_rdata[BITSIZE-1:0];
                end
            end
            if (w_frame_start && w_fifo_empty) begin
                r_underrun <= 1'b1;
            end else if (clr_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign s_ready    = !w_fifo_full;
    assign sclk       = r_sclk;
    assign lrclk      = r_lrclk;
    assign left_chan  = r_left;
    assign right_chan = r_right;
    assign frame_tick = r_frame_tick;
    assign underrun   = r_underrun;
    assign level      = w_fifo_level;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_sched
// Scoreboard bench: the stimulus queues the expected {left,right,underrun}
// for each frame; a monitor pops and compares on every frame_tick.
// Timing and status checks are made directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_i2s_tx_sched;

    localparam int unsigned BITSIZE    = 16;
    localparam int unsigned SCLK_DIV   = 2;
    localparam int unsigned SLOT       = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               enable = 1'b0;
    logic               s_valid = 1'b0;
    logic               clr_underrun = 1'b0;
    logic [BITSIZE-1:0] s_left = '0;
    logic [BITSIZE-1:0] s_right = '0;
    logic               s_ready;
    logic               sclk;
    logic               lrclk;
    logic [BITSIZE-1:0] left_chan;
    logic [BITSIZE-1:0] right_chan;
    logic               frame_tick;
    logic               underrun;
    logic [LVL_W-1:0]   level;

    always #5 clk = ~clk;

    i2s_tx_sched #(
        .BITSIZE    (BITSIZE),
        .SCLK_DIV   (SCLK_DIV),
        .SLOT       (SLOT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_left       (s_left),
        .s_right      (s_right),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .frame_tick   (frame_tick),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .level        (level)
    );

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        u;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic [15:0] l, input logic [15:0] r, input logic u);
        exp_t e;
        e.l = l;
        e.r = r;
        e.u = u;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Bounded wait for the next frame_tick; an expired bound is a failure.
    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 400);
        check(name, {31'd0, frame_tick}, 32'd1);
    endtask

    // Monitor: every presented frame must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && frame_tick) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame_unexpected: got l=%0h r=%0h want no frame",
                         left_chan, right_chan);
            end else begin
                e = sb.pop_front();
                check("frame_left", {16'd0, left_chan}, {16'd0, e.l});
                check("frame_right", {16'd0, right_chan}, {16'd0, e.r});
                check("frame_underrun", {31'd0, underrun}, {31'd0, e.u});
            end
        end
    end

    initial begin
        int   errs;
        int   rises;
        int   lr_high;
        int   ticks;
        int   misal;
        logic p_sclk;
        logic p_lr;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_lrclk", {31'd0, lrclk}, 32'd0);
        check("rst_left", {16'd0, left_chan}, 32'd0);
        check("rst_right", {16'd0, right_chan}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_ready", {31'd0, s_ready}, 32'd1);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ---------------- prefill, enable, clock generation ----------------
        push_pair(16'h1234, 16'hABCD);
        push_pair(16'h0001, 16'hFFFF);
        check("prefill_level", {29'd0, level}, 32'd2);
        sb.push_back(mk(16'h1234, 16'hABCD, 1'b0));
        sb.push_back(mk(16'h0001, 16'hFFFF, 1'b0));
        enable = 1'b1;
        wait_tick("entry_tick");
        check("entry_level", {29'd0, level}, 32'd1);
        errs = 0; rises = 0; lr_high = 0; ticks = 0; misal = 0;
        p_sclk = sclk;
        p_lr   = lrclk;
        for (int k = 1; k < 256; k++) begin
            @(negedge clk);
            if (sclk !== ((k % 4) >= 2)) errs++;
            if (lrclk !== ((k % 256) >= 128)) errs++;
            if (sclk && !p_sclk) rises++;
            if (lrclk) lr_high++;
            if ((lrclk != p_lr) && !(p_sclk && !sclk)) misal++;
            if (frame_tick) ticks++;
            p_sclk = sclk;
            p_lr   = lrclk;
        end
        check("clk_model", errs, 0);
        check("sclk_rises", rises, 64);
        check("lrclk_high", lr_high, 128);
        check("lrclk_align", misal, 0);
        check("ticks_in_frame", ticks, 0);
        @(negedge clk);
        check("frame2_at_256", {31'd0, frame_tick}, 32'd1);
        check("frame2_level", {29'd0, level}, 32'd0);

        // ---------------- underrun with coincident push ----------------
        repeat (255) @(negedge clk);
        sb.push_back(mk(16'h0000, 16'h0000, 1'b1));
        sb.push_back(mk(16'h0F0F, 16'hF0F0, 1'b0));
        s_valid = 1'b1;
        s_left  = 16'h0F0F;
        s_right = 16'hF0F0;
        @(negedge clk);
        s_valid = 1'b0;
        check("f3_tick", {31'd0, frame_tick}, 32'd1);
        check("f3_push_kept", {29'd0, level}, 32'd1);
        check("f3_underrun", {31'd0, underrun}, 32'd1);
        repeat (10) @(negedge clk);
        check("underrun_sticky", {31'd0, underrun}, 32'd1);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        check("underrun_cleared", {31'd0, underrun}, 32'd0);
        wait_tick("f4_tick");
        check("f4_level", {29'd0, level}, 32'd0);

        // ---------------- clear coincident with new underrun ----------------
        sb.push_back(mk(16'h0000, 16'h0000, 1'b1));
        repeat (255) @(negedge clk);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        check("f5_tick", {31'd0, frame_tick}, 32'd1);
        check("clr_vs_set", {31'd0, underrun}, 32'd1);

        // ---------------- stop at bit_cnt=10, re-enable, stop again ----------------
        errs = 0; ticks = 0;
        for (int k = 1; k < 256; k++) begin
            @(negedge clk);
            if (sclk !== ((k % 4) >= 2)) errs++;
            if (lrclk !== ((k % 256) >= 128)) errs++;
            if (frame_tick) ticks++;
            case (k)
                40: enable = 1'b0;
                60: begin
                    s_valid = 1'b1;
                    s_left  = 16'h5555;
                    s_right = 16'hAAAA;
                end
                61: s_valid = 1'b0;
                100: enable = 1'b1;
                120: enable = 1'b0;
                default: ;
            endcase
        end
        check("stop_clk_model", errs, 0);
        check("stop_ticks", ticks, 0);
        @(negedge clk);
        check("stop_no_pop_tick", {31'd0, frame_tick}, 32'd0);
        check("stop_sclk", {31'd0, sclk}, 32'd0);
        check("stop_lrclk", {31'd0, lrclk}, 32'd0);
        check("stop_level", {29'd0, level}, 32'd1);
        check("stop_left_held", {16'd0, left_chan}, 32'd0);
        errs = 0; ticks = 0;
        repeat (20) begin
            @(negedge clk);
            if (sclk || lrclk) errs++;
            if (frame_tick) ticks++;
        end
        check("idle_quiet", errs, 0);
        check("idle_ticks", ticks, 0);

        // ---------------- asynchronous reset mid-RUN ----------------
        push_pair(16'h1111, 16'h2222);
        push_pair(16'h3333, 16'h4444);
        push_pair(16'h5656, 16'h6565);
        check("full_level", {29'd0, level}, 32'd4);
        check("full_ready", {31'd0, s_ready}, 32'd0);
        sb.push_back(mk(16'h5555, 16'hAAAA, 1'b1));
        enable = 1'b1;
        wait_tick("f6_tick");
        check("f6_level", {29'd0, level}, 32'd3);
        repeat (130) @(negedge clk);
        check("prerst_sclk", {31'd0, sclk}, 32'd1);
        check("prerst_lrclk", {31'd0, lrclk}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_sclk", {31'd0, sclk}, 32'd0);
        check("arst_lrclk", {31'd0, lrclk}, 32'd0);
        check("arst_left", {16'd0, left_chan}, 32'd0);
        check("arst_right", {16'd0, right_chan}, 32'd0);
        check("arst_level", {29'd0, level}, 32'd0);
        check("arst_ready", {31'd0, s_ready}, 32'd1);
        check("arst_underrun", {31'd0, underrun}, 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        errs = 0; ticks = 0;
        repeat (20) begin
            @(negedge clk);
            if (sclk || lrclk) errs++;
            if (frame_tick) ticks++;
        end
        check("post_rst_idle", errs, 0);
        check("post_rst_ticks", ticks, 0);

        // ---------------- back-to-back fill, backpressure ----------------
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_left  = 16'(32'hA000 + i);
            s_right = 16'(32'hB000 + i);
            check("fill_ready", {31'd0, s_ready}, 32'd1);
            @(negedge clk);
        end
        s_left  = 16'hA004;
        s_right = 16'hB004;
        check("full_after4", {31'd0, s_ready}, 32'd0);
        check("level_after4", {29'd0, level}, 32'd4);
        @(negedge clk);
        check("fifth_held_off", {29'd0, level}, 32'd4);
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk(16'(32'hA000 + i), 16'(32'hB000 + i), 1'b0));
        end
        enable = 1'b1;
        wait_tick("g_first");
        check("g_pop_level", {29'd0, level}, 32'd3);
        check("g_ready_back", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        check("g_fifth_accepted", {29'd0, level}, 32'd4);
        repeat (4) wait_tick("g_frame");
        enable = 1'b0;
        ticks = 0;
        repeat (300) begin
            @(negedge clk);
            if (frame_tick) ticks++;
        end
        check("g_no_more_frames", ticks, 0);
        check("g_idle_sclk", {31'd0, sclk}, 32'd0);
        check("g_level_empty", {29'd0, level}, 32'd0);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
